// File: rtl/ifu_mem_fill.sv
// -----------------------------------------------------------------------------
// ifu_mem_fill
//
// Miss-fill engine on the memory side of ifu_cache. It queues miss line tags
// from the cache, fetches each line as BEATS sequential word reads, assembles
// the words into a line (beat 0 = least significant word), and returns the
// tag and line to the cache fill port with a one-cycle valid pulse.
//
// Ports
//   Clock                  in   rising-edge clock
//   Rst                    in   asynchronous reset, active low
//   ifu_reqTagIn           in   miss line tag from the cache
//   ifu_reqTagValidIn      in   miss tag valid (re-asserted every cycle by cache)
//   ifu_reqReadyOut        out  miss FIFO not full
//   mem_rdReqValidOut      out  word read request valid
//   mem_rdReqAddrOut       out  word byte address
//   mem_rdReqReadyIn       in   memory accepts the request
//   mem_rdRspValidIn       in   read data valid
//   mem_rdRspDataIn        in   read data
//   ifu_rspTagOut          out  tag of the filled line (held after the fill)
//   ifu_rspInsLineOut      out  assembled line (held after the fill)
//   ifu_rspInsLineValidOut out  one-cycle fill pulse
//   busyOut                out  fill in progress or misses queued
//   dbg_state              out  current FSM state (IDLE=0 REQ=1 WAIT=2 DONE=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge. Read responses carry no ready; memory returns exactly one response
// per accepted request, and only one request is ever outstanding.
// -----------------------------------------------------------------------------
module ifu_mem_fill #(
   parameter int ADDR_WIDTH   = 32,
   parameter int OFFSET_WIDTH = 4,
   parameter int TAG_WIDTH    = 28,
   parameter int WORD_WIDTH   = 32,
   parameter int LINE_WIDTH   = 128,
   parameter int REQ_DEPTH    = 2
) (
   input  logic                  Clock,
   input  logic                  Rst,
   input  logic [TAG_WIDTH-1:0]  ifu_reqTagIn,
   input  logic                  ifu_reqTagValidIn,
   output logic                  ifu_reqReadyOut,
   output logic                  mem_rdReqValidOut,
   output logic [ADDR_WIDTH-1:0] mem_rdReqAddrOut,
   input  logic                  mem_rdReqReadyIn,
   input  logic                  mem_rdRspValidIn,
   input  logic [WORD_WIDTH-1:0] mem_rdRspDataIn,
   output logic [TAG_WIDTH-1:0]  ifu_rspTagOut,
   output logic [LINE_WIDTH-1:0] ifu_rspInsLineOut,
   output logic                  ifu_rspInsLineValidOut,
   output logic                  busyOut,
   output logic [1:0]            dbg_state
);

   localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int BYTE_W = OFFSET_WIDTH - BEAT_W;
   localparam int PTR_W  = $clog2(REQ_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_next;

   // ---------------------------------------------------------------------------
   // Miss-tag FIFO. A per-entry valid bit lets the duplicate filter compare
   // against every live entry, including the head while its fill is running.
   // ---------------------------------------------------------------------------
   logic [TAG_WIDTH-1:0] fifo_tag [REQ_DEPTH];
   logic [REQ_DEPTH-1:0] fifo_vld;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 full, dup, push, pop;
   logic [TAG_WIDTH-1:0] head_tag;

   assign full     = (count == CNT_W'(REQ_DEPTH));
   assign head_tag = fifo_tag[rd_ptr];
   assign pop      = (state == DONE);
   // Ready comes from registered state only, so a same-cycle pop never
   // opens a slot for a push.
   assign push     = ifu_reqTagValidIn & ~full & ~dup;

   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
         if (fifo_vld[i] && (fifo_tag[i] == ifu_reqTagIn)) dup = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         fifo_vld <= '0;
         for (int i = 0; i < REQ_DEPTH; i++) fifo_tag[i] <= '0;
      end else begin
         if (pop) begin
            fifo_vld[rd_ptr] <= 1'b0;
            rd_ptr           <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            fifo_tag[wr_ptr] <= ifu_reqTagIn;
            fifo_vld[wr_ptr] <= 1'b1;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Beat counter and line assembly. asm_line collects words during a fill;
   // out_line/out_tag capture the finished fill so the outputs hold steady
   // while the next line is being assembled.
   // ---------------------------------------------------------------------------
   logic [BEAT_W-1:0]     beat;
   logic [LINE_WIDTH-1:0] asm_line;
   logic [LINE_WIDTH-1:0] out_line;
   logic [TAG_WIDTH-1:0]  out_tag;
   logic                  last_beat;

   assign last_beat = (beat == BEAT_W'(BEATS - 1));

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state    <= IDLE;
         beat     <= '0;
         asm_line <= '0;
         out_line <= '0;
         out_tag  <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: beat <= '0;
            WAIT: begin
               // Responses outside WAIT never reach this branch, so stray
               // data cannot corrupt the line.
               if (mem_rdRspValidIn) begin
                  for (int i = 0; i < BEATS; i++) begin
                     if (beat == BEAT_W'(i))
                        asm_line[i*WORD_WIDTH +: WORD_WIDTH] <= mem_rdRspDataIn;
                  end
                  if (!last_beat) beat <= beat + BEAT_W'(1);
               end
            end
            DONE: begin
               out_line <= asm_line;
               out_tag  <= head_tag;
               beat     <= '0;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next             = state;
      mem_rdReqValidOut      = 1'b0;
      mem_rdReqAddrOut       = '0;
      ifu_rspInsLineValidOut = 1'b0;
      ifu_rspTagOut          = out_tag;
      ifu_rspInsLineOut      = out_line;
      case (state)
         IDLE: begin
            if (count != '0) state_next = REQ;
         end
         REQ: begin
            mem_rdReqValidOut = 1'b1;
            mem_rdReqAddrOut  = {head_tag, beat, {BYTE_W{1'b0}}};
            if (mem_rdReqReadyIn) state_next = WAIT;
         end
         WAIT: begin
            if (mem_rdRspValidIn) state_next = last_beat ? DONE : REQ;
         end
         DONE: begin
            // The last word landed on the edge entering DONE, so asm_line is
            // complete here; show it directly rather than one cycle late.
            ifu_rspInsLineValidOut = 1'b1;
            ifu_rspTagOut          = head_tag;
            ifu_rspInsLineOut      = asm_line;
            state_next             = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ifu_reqReadyOut = ~full;
   assign busyOut         = (state != IDLE) || (count != '0);
   assign dbg_state       = state;

endmodule

// File: tb/tb_ifu_mem_fill.sv
// -----------------------------------------------------------------------------
// Bench for ifu_mem_fill: a word memory responder, a fill scoreboard fed at
// stimulus time, and one task per scenario with inline comparisons.
// -----------------------------------------------------------------------------
module tb_ifu_mem_fill;

   localparam int TW = 28;
   localparam int AW = 32;
   localparam int WW = 32;
   localparam int LW = 128;

   // ---------------------------------------------------------------- clock/reset
   logic Clock = 1'b0;
   logic Rst;
   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   logic [TW-1:0] ifu_reqTagIn;
   logic          ifu_reqTagValidIn;
   logic          ifu_reqReadyOut;
   logic          mem_rdReqValidOut;
   logic [AW-1:0] mem_rdReqAddrOut;
   logic          mem_rdReqReadyIn;
   logic          mem_rdRspValidIn;
   logic [WW-1:0] mem_rdRspDataIn;
   logic [TW-1:0] ifu_rspTagOut;
   logic [LW-1:0] ifu_rspInsLineOut;
   logic          ifu_rspInsLineValidOut;
   logic          busyOut;
   logic [1:0]    dbg_state;

   ifu_mem_fill dut (
      .Clock                  (Clock),
      .Rst                    (Rst),
      .ifu_reqTagIn           (ifu_reqTagIn),
      .ifu_reqTagValidIn      (ifu_reqTagValidIn),
      .ifu_reqReadyOut        (ifu_reqReadyOut),
      .mem_rdReqValidOut      (mem_rdReqValidOut),
      .mem_rdReqAddrOut       (mem_rdReqAddrOut),
      .mem_rdReqReadyIn       (mem_rdReqReadyIn),
      .mem_rdRspValidIn       (mem_rdRspValidIn),
      .mem_rdRspDataIn        (mem_rdRspDataIn),
      .ifu_rspTagOut          (ifu_rspTagOut),
      .ifu_rspInsLineOut      (ifu_rspInsLineOut),
      .ifu_rspInsLineValidOut (ifu_rspInsLineValidOut),
      .busyOut                (busyOut),
      .dbg_state              (dbg_state)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------------- memory model
   logic [31:0]   data_base  = 32'h0;
   bit            hash_en    = 1'b0;
   bit            force_rsp  = 1'b0;
   logic [WW-1:0] force_data = '0;
   logic [AW-1:0] req_log[$];

   function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
      logic [WW-1:0] w;
      w = data_base + {30'd0, a[3:2]};
      if (hash_en) w = w ^ {a[31:4], 4'h0};
      return w;
   endfunction

   function automatic logic [LW-1:0] exp_line(input logic [TW-1:0] t);
      logic [LW-1:0] l;
      logic [1:0]    b;
      l = '0;
      for (int i = 0; i < 4; i++) begin
         b = 2'(i);
         l[i*WW +: WW] = mem_word({t, b, 2'b00});
      end
      return l;
   endfunction

   // Accepts at most one request per cycle and answers it the next cycle.
   initial begin
      logic          hs;
      logic [AW-1:0] a;
      mem_rdRspValidIn = 1'b0;
      mem_rdRspDataIn  = '0;
      forever begin
         @(negedge Clock);
         hs = (Rst === 1'b1) && (mem_rdReqValidOut === 1'b1) && (mem_rdReqReadyIn === 1'b1);
         a  = mem_rdReqAddrOut;
         @(posedge Clock);
         #1;
         if (hs) begin
            req_log.push_back(a);
            mem_rdRspValidIn = 1'b1;
            mem_rdRspDataIn  = mem_word(a);
         end else if (force_rsp) begin
            mem_rdRspValidIn = 1'b1;
            mem_rdRspDataIn  = force_data;
         end else begin
            mem_rdRspValidIn = 1'b0;
            mem_rdRspDataIn  = '0;
         end
      end
   end

   // ---------------------------------------------------------------- scoreboard
   logic [TW+LW-1:0] exp_q[$];
   logic [TW+LW-1:0] mon_exp;
   int               fill_count = 0;
   int               fill_cycles[$];

   always @(negedge Clock) begin
      if (Rst === 1'b1 && ifu_rspInsLineValidOut === 1'b1) begin
         fill_count++;
         fill_cycles.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL fill_unexpected tag=%h line=%h", ifu_rspTagOut, ifu_rspInsLineOut);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({ifu_rspTagOut, ifu_rspInsLineOut} !== mon_exp) begin
               failures++;
               $display("FAIL fill_data got tag=%h line=%h want tag=%h line=%h",
                        ifu_rspTagOut, ifu_rspInsLineOut, mon_exp[TW+LW-1:LW], mon_exp[LW-1:0]);
            end
         end
      end
   end

   // Waits (bounded) until the fill counter reaches target; ends on a posedge.
   task automatic wait_fills(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clock);
         if (fill_count >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      Rst = 1'b0;
      repeat (2) @(negedge Clock);
      checks++; if (ifu_reqReadyOut !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ifu_reqReadyOut); end
      checks++; if (mem_rdReqValidOut !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", mem_rdReqValidOut); end
      checks++; if (mem_rdReqAddrOut !== '0) begin failures++; $display("FAIL reset_req_addr got=%h want=0", mem_rdReqAddrOut); end
      checks++; if (ifu_rspInsLineValidOut !== 1'b0) begin failures++; $display("FAIL reset_fill_valid got=%b want=0", ifu_rspInsLineValidOut); end
      checks++; if (ifu_rspTagOut !== '0) begin failures++; $display("FAIL reset_tag got=%h want=0", ifu_rspTagOut); end
      checks++; if (ifu_rspInsLineOut !== '0) begin failures++; $display("FAIL reset_line got=%h want=0", ifu_rspInsLineOut); end
      checks++; if (busyOut !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busyOut); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
      @(posedge Clock); #1;
      Rst = 1'b1;
      @(posedge Clock); #1;
   endtask

   task automatic test_single_miss();
      int f0, n, lat;
      bit ok;
      logic [AW-1:0] want_addr;
      data_base = 32'hA0; hash_en = 1'b0;
      req_log.delete();
      f0 = fill_count;
      ifu_reqTagIn = 28'h1234567; ifu_reqTagValidIn = 1'b1; n = cyc;
      exp_q.push_back({28'h1234567, exp_line(28'h1234567)});
      @(posedge Clock); #1;
      ifu_reqTagValidIn = 1'b0;
      wait_fills(f0 + 1, 40, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL single_timeout got=%0d fills want=%0d", fill_count - f0, 1);
      end else begin
         lat = fill_cycles[f0] - n;
         if (lat != 10) begin failures++; $display("FAIL single_latency got=%0d want=10", lat); end
      end
      checks++; if (req_log.size() != 4) begin failures++; $display("FAIL single_req_count got=%0d want=4", req_log.size()); end
      for (int i = 0; i < 4 && i < req_log.size(); i++) begin
         want_addr = 32'h12345670 + 32'(4 * i);
         checks++; if (req_log[i] !== want_addr) begin failures++; $display("FAIL single_addr%0d got=%h want=%h", i, req_log[i], want_addr); end
      end
      @(negedge Clock);
      checks++; if (ifu_rspInsLineValidOut !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b want=0", ifu_rspInsLineValidOut); end
      checks++; if (ifu_rspInsLineOut !== 128'h000000A3_000000A2_000000A1_000000A0) begin failures++; $display("FAIL single_line_hold got=%h want=000000a3000000a2000000a1000000a0", ifu_rspInsLineOut); end
      checks++; if (ifu_rspTagOut !== 28'h1234567) begin failures++; $display("FAIL single_tag_hold got=%h want=1234567", ifu_rspTagOut); end
      checks++; if (busyOut !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b want=0", busyOut); end
      @(posedge Clock); #1;
   endtask

   task automatic test_duplicate();
      int f0;
      bit ok;
      data_base = 32'h1000; hash_en = 1'b1;
      req_log.delete();
      f0 = fill_count;
      ifu_reqTagIn = 28'h1234567; ifu_reqTagValidIn = 1'b1;
      exp_q.push_back({28'h1234567, exp_line(28'h1234567)});
      repeat (8) begin @(posedge Clock); #1; end
      ifu_reqTagValidIn = 1'b0;
      wait_fills(f0 + 1, 40, ok);
      checks++; if (!ok) begin failures++; $display("FAIL dup_timeout got=%0d fills want=1", fill_count - f0); end
      repeat (12) @(posedge Clock);
      #1;
      checks++; if (fill_count - f0 != 1) begin failures++; $display("FAIL dup_fill_count got=%0d want=1", fill_count - f0); end
      checks++; if (req_log.size() != 4) begin failures++; $display("FAIL dup_req_count got=%0d want=4", req_log.size()); end
   endtask

   task automatic test_full();
      int f0, k, acc_cyc, budget, d;
      bit ok, accepted;
      logic [TW-1:0] ta, tb_, tc;
      ta = 28'hAAAAAA1; tb_ = 28'hBBBBBB2; tc = 28'hCCCCCC3;
      data_base = 32'h2000; hash_en = 1'b1;
      req_log.delete();
      f0 = fill_count;
      exp_q.push_back({ta,  exp_line(ta)});
      exp_q.push_back({tb_, exp_line(tb_)});
      exp_q.push_back({tc,  exp_line(tc)});
      ifu_reqTagIn = ta; ifu_reqTagValidIn = 1'b1; k = cyc;
      @(posedge Clock); #1; ifu_reqTagIn = tb_;
      @(posedge Clock); #1; ifu_reqTagIn = tc;
      @(negedge Clock);
      checks++; if (ifu_reqReadyOut !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", ifu_reqReadyOut); end
      checks++; if (busyOut !== 1'b1) begin failures++; $display("FAIL full_busy got=%b want=1", busyOut); end
      accepted = 1'b0; acc_cyc = 0; budget = 0;
      while (!accepted && budget < 40) begin
         if (ifu_reqReadyOut === 1'b1) begin accepted = 1'b1; acc_cyc = cyc; end
         @(posedge Clock); #1;
         if (!accepted) @(negedge Clock);
         budget++;
      end
      ifu_reqTagValidIn = 1'b0;
      wait_fills(f0 + 3, 80, ok);
      checks++; if (!accepted || !ok) begin failures++; $display("FAIL full_timeout got accepted=%0d fills=%0d want accepted=1 fills=3", accepted, fill_count - f0); end
      if (accepted && ok) begin
         d = fill_cycles[f0] - k;
         checks++; if (d != 10) begin failures++; $display("FAIL full_a_latency got=%0d want=10", d); end
         d = acc_cyc - fill_cycles[f0];
         checks++; if (d != 1) begin failures++; $display("FAIL full_c_accept got=%0d want=1 cycles after A done", d); end
         d = fill_cycles[f0 + 1] - fill_cycles[f0];
         checks++; if (d != 10) begin failures++; $display("FAIL full_b_spacing got=%0d want=10", d); end
         d = fill_cycles[f0 + 2] - fill_cycles[f0 + 1];
         checks++; if (d != 10) begin failures++; $display("FAIL full_c_spacing got=%0d want=10", d); end
      end
      checks++; if (req_log.size() != 12) begin failures++; $display("FAIL full_req_count got=%0d want=12", req_log.size()); end
      #1;
   endtask

   task automatic test_backpressure();
      int f0, n, lat;
      bit ok;
      logic [TW-1:0] t;
      logic [AW-1:0] a78;
      t = 28'hBADF00D; a78 = {t, 2'b10, 2'b00};
      data_base = 32'h3000; hash_en = 1'b1;
      req_log.delete();
      f0 = fill_count;
      ifu_reqTagIn = t; ifu_reqTagValidIn = 1'b1; n = cyc;
      exp_q.push_back({t, exp_line(t)});
      @(posedge Clock); #1;
      ifu_reqTagValidIn = 1'b0;
      repeat (5) @(posedge Clock);
      #1;
      mem_rdReqReadyIn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         checks++; if (mem_rdReqValidOut !== 1'b1) begin failures++; $display("FAIL bp_valid_hold%0d got=%b want=1", i, mem_rdReqValidOut); end
         checks++; if (mem_rdReqAddrOut !== a78) begin failures++; $display("FAIL bp_addr_hold%0d got=%h want=%h", i, mem_rdReqAddrOut, a78); end
         @(posedge Clock);
      end
      #1;
      mem_rdReqReadyIn = 1'b1;
      checks++; if (req_log.size() != 2) begin failures++; $display("FAIL bp_no_accept got=%0d want=2", req_log.size()); end
      wait_fills(f0 + 1, 40, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL bp_timeout got=%0d fills want=1", fill_count - f0);
      end else begin
         lat = fill_cycles[f0] - n;
         if (lat != 13) begin failures++; $display("FAIL bp_latency got=%0d want=13", lat); end
      end
      checks++; if (req_log.size() != 4) begin failures++; $display("FAIL bp_req_count got=%0d want=4", req_log.size()); end
      #1;
   endtask

   task automatic test_stray();
      int f0, n, lat;
      bit ok;
      logic [TW-1:0] t;
      f0 = fill_count;
      @(negedge Clock);
      force_data = 32'hFFFFFFFF; force_rsp = 1'b1;
      repeat (2) @(negedge Clock);
      force_rsp = 1'b0;
      @(posedge Clock); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         checks++; if (ifu_rspInsLineValidOut !== 1'b0) begin failures++; $display("FAIL stray_pulse%0d got=%b want=0", i, ifu_rspInsLineValidOut); end
         checks++; if (busyOut !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL stray_idle%0d got busy=%b state=%0d want busy=0 state=0", i, busyOut, dbg_state); end
      end
      checks++; if (ifu_rspTagOut !== 28'hBADF00D) begin failures++; $display("FAIL stray_tag_hold got=%h want=badf00d", ifu_rspTagOut); end
      @(posedge Clock); #1;
      t = 28'h0C0FFEE;
      data_base = 32'h50; hash_en = 1'b0;
      ifu_reqTagIn = t; ifu_reqTagValidIn = 1'b1; n = cyc;
      exp_q.push_back({t, exp_line(t)});
      @(posedge Clock); #1;
      ifu_reqTagValidIn = 1'b0;
      wait_fills(f0 + 1, 40, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL stray_next_timeout got=%0d fills want=1", fill_count - f0);
      end else begin
         lat = fill_cycles[f0] - n;
         if (lat != 10) begin failures++; $display("FAIL stray_next_latency got=%0d want=10", lat); end
      end
      #1;
   endtask

   task automatic test_reset_mid_fill();
      int f0, n, lat;
      bit ok;
      logic [TW-1:0] t;
      t = 28'h7654321;
      data_base = 32'h4000; hash_en = 1'b1;
      req_log.delete();
      f0 = fill_count;
      ifu_reqTagIn = t; ifu_reqTagValidIn = 1'b1;
      @(posedge Clock); #1;
      ifu_reqTagValidIn = 1'b0;
      repeat (5) @(posedge Clock);
      #1;
      Rst = 1'b0;
      @(negedge Clock);
      checks++; if (req_log.size() != 2) begin failures++; $display("FAIL rst_beats_before got=%0d want=2", req_log.size()); end
      checks++; if (ifu_reqReadyOut !== 1'b1 || busyOut !== 1'b0) begin failures++; $display("FAIL rst_ready_busy got ready=%b busy=%b want ready=1 busy=0", ifu_reqReadyOut, busyOut); end
      checks++; if (mem_rdReqValidOut !== 1'b0 || mem_rdReqAddrOut !== '0) begin failures++; $display("FAIL rst_req got valid=%b addr=%h want 0/0", mem_rdReqValidOut, mem_rdReqAddrOut); end
      checks++; if (ifu_rspInsLineValidOut !== 1'b0 || ifu_rspTagOut !== '0 || ifu_rspInsLineOut !== '0) begin failures++; $display("FAIL rst_fill_out got valid=%b tag=%h line=%h want all 0", ifu_rspInsLineValidOut, ifu_rspTagOut, ifu_rspInsLineOut); end
      @(posedge Clock); #1;
      Rst = 1'b1;
      @(negedge Clock);
      force_data = 32'hDEADBEEF; force_rsp = 1'b1;
      @(negedge Clock);
      force_rsp = 1'b0;
      @(posedge Clock); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         checks++; if (busyOut !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL rst_late_rsp%0d got busy=%b state=%0d want busy=0 state=0", i, busyOut, dbg_state); end
      end
      checks++; if (fill_count != f0) begin failures++; $display("FAIL rst_no_fill got=%0d want=0", fill_count - f0); end
      @(posedge Clock); #1;
      t = 28'h0FEDCBA;
      data_base = 32'h5000; hash_en = 1'b1;
      ifu_reqTagIn = t; ifu_reqTagValidIn = 1'b1; n = cyc;
      exp_q.push_back({t, exp_line(t)});
      @(posedge Clock); #1;
      ifu_reqTagValidIn = 1'b0;
      wait_fills(f0 + 1, 40, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL rst_refill_timeout got=%0d fills want=1", fill_count - f0);
      end else begin
         lat = fill_cycles[f0] - n;
         if (lat != 10) begin failures++; $display("FAIL rst_refill_latency got=%0d want=10", lat); end
      end
      #1;
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      Rst               = 1'b0;
      ifu_reqTagIn      = '0;
      ifu_reqTagValidIn = 1'b0;
      mem_rdReqReadyIn  = 1'b1;
      test_reset();
      test_single_miss();
      test_duplicate();
      test_full();
      test_backpressure();
      test_stray();
      test_reset_mid_fill();
      repeat (3) @(posedge Clock);
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
